// File: rtl/pipe_issue_if.sv
// Control/fetch/writeback bundle between the issue controller and the host, imem and datapath.
interface pipe_issue_if #(
  parameter int PC_W  = 3,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PC_W:0]    prog_len;
  logic [PC_W-1:0]  imem_addr;
  logic [11:0]      imem_data;
  logic [11:0]      ex_instr;
  logic             ex_fire;
  logic             wb_we;
  logic [3:0]       wb_rd;
  logic             stall;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  start, prog_len, imem_data,
    output imem_addr, ex_instr, ex_fire, wb_we, wb_rd, stall, busy, done, stall_cnt
  );

  modport slave (
    output start, prog_len, imem_data,
    input  imem_addr, ex_instr, ex_fire, wb_we, wb_rd, stall, busy, done, stall_cnt
  );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// Issue/hazard controller for the 3-stage ALU pipe; fetches prog_len instructions from pc 0.
// Instruction k reaches WB 3+k edges after start plus stalls; a RAW hit against WB costs one bubble.
module pipe_issue_ctrl #(
  parameter int PC_W  = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  pipe_issue_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [PC_W:0]    len_q, fetched_q;
  logic [PC_W-1:0]  pc_q;
  logic [11:0]      if_instr_q, ex_instr_q;
  logic             if_v_q, ex_v_q, wb_v_q;
  logic [3:0]       wb_op_q, wb_rd_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic ex_rw, wb_we_c, stall, start_acc, fetch, pipe_empty;

  assign ex_rw      = ex_v_q && (ex_instr_q[11:8] == 4'd0 || ex_instr_q[11:8] == 4'd1);
  assign wb_we_c    = wb_v_q && (wb_op_q == 4'd0 || wb_op_q == 4'd1);
  assign stall      = ex_rw && wb_we_c &&
                      (ex_instr_q[7:4] == wb_rd_q || ex_instr_q[3:0] == wb_rd_q);
  assign start_acc  = (state_q == IDLE) && bus.start;
  assign fetch      = (state_q == RUN) && (fetched_q < len_q) && !stall;
  assign pipe_empty = !if_v_q && !ex_v_q && !wb_v_q;

  // An empty program reaches RUN with nothing in flight and finishes straight from there.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN: begin
        if (fetched_q == len_q) begin
          if (pipe_empty) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      len_q       <= '0;
      fetched_q   <= '0;
      pc_q        <= '0;
      if_instr_q  <= '0;
      ex_instr_q  <= '0;
      if_v_q      <= 1'b0;
      ex_v_q      <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_op_q     <= '0;
      wb_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        len_q       <= bus.prog_len;
        fetched_q   <= '0;
        pc_q        <= '0;
        if_v_q      <= 1'b0;
        ex_v_q      <= 1'b0;
        wb_v_q      <= 1'b0;
        stall_cnt_q <= '0;
      end else if (stall) begin
        // IF and EX hold; WB empties, which is what clears the hazard next cycle.
        wb_v_q <= 1'b0;
        if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end else begin
        if (fetch) begin
          if_instr_q <= bus.imem_data;
          if_v_q     <= 1'b1;
          fetched_q  <= fetched_q + (PC_W+1)'(1);
          pc_q       <= pc_q + PC_W'(1);
        end else begin
          if_v_q <= 1'b0;
        end
        ex_instr_q <= if_instr_q;
        ex_v_q     <= if_v_q;
        wb_v_q     <= ex_v_q;
        wb_rd_q    <= ex_instr_q[7:4];
        wb_op_q    <= ex_instr_q[11:8];
      end
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.ex_instr  = ex_instr_q;
  assign bus.ex_fire   = ex_v_q && !stall;
  assign bus.wb_we     = wb_we_c;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.stall     = stall;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed program table, hand-written reset/start corners, random programs
// checked against a sequential-execution model of the program.
module tb_pipe_issue_ctrl;
  localparam int PC_W  = 3;
  localparam int CNT_W = 8;

  logic clk, rst;
  pipe_issue_if #(.PC_W(PC_W), .CNT_W(CNT_W)) ifc ();
  pipe_issue_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] prog [8];
  assign ifc.imem_data = prog[ifc.imem_addr];

  // Datapath stand-in: register file plus the EX result register.
  logic [7:0] rf [16];
  logic [7:0] res_q;
  logic       rf_init;
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'(i);
      res_q <= '0;
    end else begin
      if (ifc.wb_we) rf[ifc.wb_rd] <= res_q;
      if (ifc.ex_fire)
        res_q <= (ifc.ex_instr[11:8] == 4'd0) ? rf[ifc.ex_instr[7:4]] + rf[ifc.ex_instr[3:0]]
                                              : rf[ifc.ex_instr[7:4]] - rf[ifc.ex_instr[3:0]];
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: run the program in order; a stall is owed whenever an ADD/SUB reads the
  // register written by the ADD/SUB directly before it.
  logic [7:0] mrf [16];
  logic [3:0] exp_rd [$];
  int         exp_st, exp_done;

  task automatic model(input int len);
    logic [3:0] pd;
    bit         pw;
    exp_rd.delete();
    exp_st = 0;
    pw = 0;
    pd = '0;
    for (int i = 0; i < 16; i++) mrf[i] = rf[i];
    for (int i = 0; i < len; i++) begin
      logic [3:0] op, a, b;
      op = prog[i][11:8];
      a  = prog[i][7:4];
      b  = prog[i][3:0];
      if (op < 4'd2) begin
        if (pw && (pd == a || pd == b)) exp_st++;
        mrf[a] = (op == 4'd0) ? mrf[a] + mrf[b] : mrf[a] - mrf[b];
        exp_rd.push_back(a);
      end
      pw = (op < 4'd2);
      pd = a;
    end
    exp_done = (len == 0) ? 1 : len + 4 + exp_st;
  endtask

  // Observations from one program run.
  logic [3:0]       g_rd [$];
  int               g_done, g_st, g_nfire, g_addr_bad, g_notbusy;
  logic             g_busy;
  logic [CNT_W-1:0] g_cnt;
  logic [PC_W-1:0]  g_pc;

  task automatic run_prog(input int len, input int inj, input bit b2b);
    int cyc;
    if (!b2b) @(negedge clk);
    ifc.prog_len = (PC_W+1)'(len);
    ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    cyc = 0; g_st = 0; g_nfire = 0; g_addr_bad = 0; g_notbusy = 0;
    g_rd.delete();
    forever begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.done) break;
      if (cyc < len && ifc.imem_addr != PC_W'(cyc)) g_addr_bad++;
      if (!ifc.busy) g_notbusy++;
      if (ifc.stall) g_st++;
      if (ifc.ex_fire) g_nfire++;
      if (ifc.wb_we) g_rd.push_back(ifc.wb_rd);
      if (cyc == inj) begin
        ifc.start = 1'b1;
        ifc.prog_len = (PC_W+1)'(1);
      end
      cyc++;
      if (cyc > 200) break;
    end
    g_done = cyc;
    g_busy = ifc.busy;
    g_cnt  = ifc.stall_cnt;
    g_pc   = ifc.imem_addr;
    if (cyc > 200) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic check_common(input string tag, input int len);
    bit ok;
    ok = (g_rd.size() == exp_rd.size());
    if (ok) foreach (g_rd[i]) if (g_rd[i] !== exp_rd[i]) ok = 0;
    chk({tag, "_wb_rd_seq"}, 32'(ok), 32'd1);
    chk({tag, "_nwe"}, 32'(g_rd.size()), 32'(exp_rd.size()));
    chk({tag, "_nfire"}, 32'(g_nfire), 32'(len));
    chk({tag, "_busy_at_done"}, 32'(g_busy), 32'd0);
    chk({tag, "_busy_while_run"}, 32'(g_notbusy), 32'd0);
    chk({tag, "_pc_end"}, 32'(g_pc), 32'(len % 8));
    ok = 1;
    for (int i = 0; i < 16; i++) if (rf[i] !== mrf[i]) ok = 0;
    chk({tag, "_regfile"}, 32'(ok), 32'd1);
  endtask

  task automatic rf_reset();
    @(negedge clk) rf_init = 1'b1;
    @(negedge clk) rf_init = 1'b0;
  endtask

  typedef struct {
    int               len;
    logic [0:7][11:0] ins;
    int               exp_done;
    int               exp_st;
    int               exp_r1;
    int               inj;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [31:0] outs();
    return {ifc.imem_addr, ifc.ex_instr, ifc.ex_fire, ifc.wb_we, ifc.wb_rd,
            ifc.stall, ifc.busy, ifc.done, ifc.stall_cnt};
  endfunction

  initial begin
    vecs[0] = '{4, {12'h012, 12'h034, 12'h156, 12'h078, 12'h0, 12'h0, 12'h0, 12'h0}, 8, 0, -1, -1};
    vecs[1] = '{2, {12'h012, 12'h013, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}, 7, 1, 6, -1};
    vecs[2] = '{2, {12'hF12, 12'h013, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}, 6, 0, -1, -1};
    vecs[3] = '{8, {12'h012, 12'h034, 12'h056, 12'h078, 12'h09A, 12'h0BC, 12'h0DE, 12'h0F0},
                12, 0, -1, -1};
    vecs[4] = '{0, {12'h012, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}, 1, 0, -1, -1};
    vecs[5] = '{4, {12'h012, 12'h013, 12'h014, 12'h015, 12'h0, 12'h0, 12'h0, 12'h0}, 11, 3, -1, 5};

    rst = 1'b1;
    rf_init = 1'b1;
    ifc.start = 1'b0;
    ifc.prog_len = '0;
    for (int i = 0; i < 8; i++) prog[i] = '0;
    #2;
    chk("reset_outputs", outs(), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rf_init = 1'b0;
    @(negedge clk);
    chk("idle_outputs", outs(), 32'd0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      rf_reset();
      for (int i = 0; i < 8; i++) prog[i] = vecs[v].ins[i];
      model(vecs[v].len);
      run_prog(vecs[v].len, vecs[v].inj, 1'b0);
      chk({tag, "_done_cycle"}, 32'(g_done), 32'(vecs[v].exp_done));
      chk({tag, "_stall_cycles"}, 32'(g_st), 32'(vecs[v].exp_st));
      chk({tag, "_stall_cnt"}, 32'(g_cnt), 32'(vecs[v].exp_st));
      if (vecs[v].exp_st == 0) chk({tag, "_imem_addr_seq"}, 32'(g_addr_bad), 32'd0);
      if (vecs[v].exp_r1 >= 0) chk({tag, "_r1"}, 32'(rf[1]), 32'(vecs[v].exp_r1));
      check_common(tag, vecs[v].len);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(ifc.done), 32'd0);
    end

    // Reset asserted mid-program, between clock edges.
    for (int i = 0; i < 8; i++) prog[i] = vecs[3].ins[i];
    @(negedge clk);
    ifc.prog_len = 4'd8;
    ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("midrun_reset_outputs", outs(), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (ifc.done) seen++;
      end
      rst = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (ifc.done || ifc.busy) seen++;
      end
      chk("midrun_reset_no_done", 32'(seen), 32'd0);
    end

    // Random programs, sometimes started in the done cycle of the previous one.
    rf_reset();
    begin
      bit b2b;
      b2b = 0;
      for (int t = 0; t < 40; t++) begin
        int len;
        len = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) begin
          int r;
          r = $urandom_range(0, 5);
          prog[i] = {(r < 2) ? 4'(r) : 4'(r + 8), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        end
        model(len);
        run_prog(len, -1, b2b);
        chk($sformatf("rnd%0d_done_cycle", t), 32'(g_done), 32'(exp_done));
        chk($sformatf("rnd%0d_stall_cycles", t), 32'(g_st), 32'(exp_st));
        chk($sformatf("rnd%0d_stall_cnt", t), 32'(g_cnt), 32'(exp_st));
        check_common($sformatf("rnd%0d", t), len);
        b2b = 1'($urandom_range(0, 1));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
